// File: rtl/scalar_br_pkg.sv
// Shared types for the scalar branch unit: condition codes, FSM states and
// the bit positions of {zero, sign, overflow} inside the flag vector.
package scalar_br_pkg;

  typedef enum logic [2:0] {
    COND_NE     = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GE     = 3'b100,
    COND_LE     = 3'b101,
    COND_OV     = 3'b110,
    COND_ALWAYS = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/scalar_branch_unit_if.sv
// Redirect channel from the branch unit to fetch: corrected PC with a
// valid/ready handshake. The branch unit is the master.
interface scalar_branch_unit_if #(
  parameter int PC_W = 36
);

  logic            redirect_valid;
  logic            redirect_ready;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );

endinterface

// File: rtl/scalar_br_cond_eval.sv
// Combinational condition evaluation: (cond, Z, S, V) -> taken.
// Also used by the execute-side predicated operations.
module scalar_br_cond_eval
  import scalar_br_pkg::*;
(
  input  br_cond_e cond_i,
  input  logic     z_i,
  input  logic     s_i,
  input  logic     v_i,
  output logic     taken_o
);

  logic lt;
  assign lt = s_i ^ v_i;

  // NOTE: every output of an always_comb gets a default before the case so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_NE:     taken_o = ~z_i;
      COND_EQ:     taken_o = z_i;
      COND_GT:     taken_o = ~z_i & ~lt;
      COND_LT:     taken_o = lt;
      COND_GE:     taken_o = ~lt;
      COND_LE:     taken_o = z_i | lt;
      COND_OV:     taken_o = v_i;
      COND_ALWAYS: taken_o = 1'b1;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/scalar_branch_unit.sv
// Branch resolution beside execute: flag register, mispredict detection,
// registered redirect to fetch, then a fixed-length flush of younger stages.
// Optional feature macro: SCALAR_BR_PERF_EN adds branch/mispredict counters.
module scalar_branch_unit
  import scalar_br_pkg::*;
#(
  parameter int PC_W         = 36,
  parameter int DATA_W       = 36,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_set_flags,
  input  logic                 zero,
  input  logic                 sign,
  input  logic                 overflow,
  input  logic [DATA_W-1:0]    ex_data,
  input  logic                 br_valid,
  input  logic [2:0]           br_cond,
  input  logic                 br_indirect,
  input  logic [PC_W-1:0]      br_pc,
  input  logic [24:0]          br_offset,
  input  logic                 br_pred_taken,
  scalar_branch_unit_if.master redir,
  output logic                 flush,
  output logic                 stall,
  output logic [FLAG_W-1:0]    flags
`ifdef SCALAR_BR_PERF_EN
  ,
  output logic [31:0]          br_count,
  output logic [31:0]          mispredict_count
`endif
);

  localparam int CNT_W       = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int CNT_LOAD_I  = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_LOAD_I[CNT_W-1:0];

  br_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [FLAG_W-1:0] flags_q;

  logic              idle;
  logic [FLAG_W-1:0] live_flags;
  logic [FLAG_W-1:0] src_flags;
  logic              taken;
  logic              mispredict;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   fall_through;
  logic [PC_W-1:0]   corrected_pc;

  assign idle       = (state_q == IDLE);
  assign live_flags = {zero, sign, overflow};
  // Fused compare-branch sees this instruction's own flags, not the register.
  assign src_flags  = (ex_set_flags & br_valid) ? live_flags : flags_q;

  scalar_br_cond_eval u_cond_eval (
    .cond_i  (br_cond_e'(br_cond)),
    .z_i     (src_flags[FLAG_Z]),
    .s_i     (src_flags[FLAG_S]),
    .v_i     (src_flags[FLAG_V]),
    .taken_o (taken)
  );

  assign target       = br_indirect ? ex_data[PC_W-1:0]
                                    : br_pc + PC_W'($signed(br_offset));
  assign fall_through = br_pc + 1'b1;
  assign corrected_pc = taken ? target : fall_through;
  assign mispredict   = idle & ex_valid & br_valid & (taken != br_pred_taken);

  if (DATA_W > PC_W) begin : g_data_hi
    logic unused_data_hi;
    assign unused_data_hi = ^ex_data[DATA_W-1:PC_W];
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (idle & ex_valid & ex_set_flags) begin
      flags_q <= live_flags;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          redirect_pc_d = corrected_pc;
          state_d       = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir.redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redir.redirect_valid = (state_q == REDIRECT);
    redir.redirect_pc    = redirect_pc_q;
    stall                = (state_q == REDIRECT);
    flush                = (state_q != IDLE);
    flags                = flags_q;
  end

`ifdef SCALAR_BR_PERF_EN
  logic [31:0] br_count_q, mispredict_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q         <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (idle & ex_valid & br_valid & (br_count_q != '1)) begin
        br_count_q <= br_count_q + 1'b1;
      end
      if (mispredict & (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + 1'b1;
      end
    end
  end

  assign br_count         = br_count_q;
  assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_scalar_branch_unit.sv
// Self-checking bench for scalar_branch_unit: directed scenarios plus a
// randomized sweep against an arithmetic reference model.
module tb_scalar_branch_unit;

  localparam int PC_W   = 36;
  localparam int DATA_W = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_set_flags, zero, sign, overflow;
  logic [DATA_W-1:0] ex_data;
  logic              br_valid, br_indirect, br_pred_taken;
  logic [2:0]        br_cond;
  logic [PC_W-1:0]   br_pc;
  logic [24:0]       br_offset;

  logic       flush0, stall0, flush1, stall1;
  logic [2:0] flags0, flags1;
`ifdef SCALAR_BR_PERF_EN
  logic [31:0] brc0, misc0, brc1, misc1;
`endif

  int         passed = 0;
  int         total  = 0;
  logic [2:0] model_flags;

  always #5 clk = ~clk;

  scalar_branch_unit_if #(.PC_W(PC_W)) rif0 ();
  scalar_branch_unit_if #(.PC_W(PC_W)) rif1 ();

  scalar_branch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .zero(zero), .sign(sign), .overflow(overflow), .ex_data(ex_data),
    .br_valid(br_valid), .br_cond(br_cond), .br_indirect(br_indirect),
    .br_pc(br_pc), .br_offset(br_offset), .br_pred_taken(br_pred_taken),
    .redir(rif0), .flush(flush0), .stall(stall0), .flags(flags0)
`ifdef SCALAR_BR_PERF_EN
    , .br_count(brc0), .mispredict_count(misc0)
`endif
  );

  scalar_branch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .FLUSH_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .zero(zero), .sign(sign), .overflow(overflow), .ex_data(ex_data),
    .br_valid(br_valid), .br_cond(br_cond), .br_indirect(br_indirect),
    .br_pc(br_pc), .br_offset(br_offset), .br_pred_taken(br_pred_taken),
    .redir(rif1), .flush(flush1), .stall(stall1), .flags(flags1)
`ifdef SCALAR_BR_PERF_EN
    , .br_count(brc1), .mispredict_count(misc1)
`endif
  );

  // ---------------- reference model ----------------
  function automatic bit ref_taken(bit [2:0] c, bit z, bit s, bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && (s == v);
      3'd3: return s != v;
      3'd4: return s == v;
      3'd5: return z || (s != v);
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [35:0] ref_wrap(longint t);
    longint m;
    longint r;
    m = longint'(1) << 36;
    r = ((t % m) + m) % m;
    return r[35:0];
  endfunction

  function automatic logic [35:0] ref_target(logic [35:0] pc, logic [24:0] off);
    return ref_wrap(longint'(pc) + longint'($signed(off)));
  endfunction

  function automatic logic [35:0] ref_fall(logic [35:0] pc);
    return ref_wrap(longint'(pc) + 1);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_set_flags = 0; zero = 0; sign = 0; overflow = 0;
    ex_data = '0; br_valid = 0; br_cond = 3'd0; br_indirect = 0;
    br_pc = '0; br_offset = '0; br_pred_taken = 0;
  endtask

  task automatic drive_branch(bit [2:0] c, bit pred, logic [35:0] pc,
                              logic [24:0] off, bit ind, logic [35:0] data);
    ex_valid = 1; br_valid = 1; br_cond = c; br_pred_taken = pred;
    br_pc = pc; br_offset = off; br_indirect = ind; ex_data = data;
  endtask

  // A surely-mispredicting branch with a flag write; must be ignored.
  task automatic drive_junk();
    drive_branch(3'd7, 1'b0, 36'h0ABC, 25'd3, 1'b0, 36'h0);
    ex_set_flags = 1;
    {zero, sign, overflow} = 3'($urandom_range(0, 7));
  endtask

  // Entered right after the edge that raised redirect_valid on dut0.
  task automatic drain(int hold, logic [35:0] exp_pc, bit inject, string tag);
    logic [2:0] obs;
    clear_inputs();
    for (int i = 0; i < hold; i++) begin
      if (inject) drive_junk();
      rif0.redirect_ready = 0;
      tick();
      obs = {rif0.redirect_valid, stall0, flush0};
      total++;
      if (obs !== 3'b111 || rif0.redirect_pc !== exp_pc) begin
        $display("FAIL %s hold%0d: vsf=%b pc=%h expected vsf=111 pc=%h",
                 tag, i, obs, rif0.redirect_pc, exp_pc);
      end else passed++;
    end
    if (inject) drive_junk();
    rif0.redirect_ready = 1;
    tick();
    rif0.redirect_ready = 0;
    for (int i = 0; i < 3; i++) begin
      obs = {rif0.redirect_valid, stall0, flush0};
      total++;
      if (obs !== ((i < 2) ? 3'b001 : 3'b000)) begin
        $display("FAIL %s flush%0d: vsf=%b expected %b",
                 tag, i, obs, (i < 2) ? 3'b001 : 3'b000);
      end else passed++;
      if (i < 2) begin
        if (inject) drive_junk();
        tick();
      end
    end
    clear_inputs();
    total++;
    if (flags0 !== model_flags) begin
      $display("FAIL %s flags_after: got %b expected %b", tag, flags0, model_flags);
    end else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [2:0] obs;
    rst = 1;
    clear_inputs();
    rif0.redirect_ready = 0;
    rif1.redirect_ready = 1;
    model_flags = 3'b000;
    tick(); tick();
    obs = {rif0.redirect_valid, stall0, flush0};
    total++;
    if (obs !== 3'b000 || flags0 !== 3'b000 || rif0.redirect_pc !== '0) begin
      $display("FAIL reset_state: vsf=%b flags=%b pc=%h expected all zero",
               obs, flags0, rif0.redirect_pc);
    end else passed++;
    #2 rst = 0;

    tick();
    ex_valid = 1; ex_set_flags = 1; {zero, sign, overflow} = 3'b111;
    tick();
    clear_inputs();
    drive_branch(3'd7, 1'b0, 36'h500, 25'd16, 1'b0, 36'h0);
    tick();
    clear_inputs();
    total++;
    if (rif0.redirect_valid !== 1'b1 || flags0 !== 3'b111) begin
      $display("FAIL reset_setup: rv=%b flags=%b expected rv=1 flags=111",
               rif0.redirect_valid, flags0);
    end else passed++;
    #2 rst = 1;
    #1;
    obs = {rif0.redirect_valid, stall0, flush0};
    total++;
    if (obs !== 3'b000 || flags0 !== 3'b000 || rif0.redirect_pc !== '0) begin
      $display("FAIL reset_async: vsf=%b flags=%b pc=%h expected all zero",
               obs, flags0, rif0.redirect_pc);
    end else passed++;
    #2 rst = 0;
    model_flags = 3'b000;
    tick();
    total++;
    if (rif0.redirect_valid !== 1'b0 || flush0 !== 1'b0) begin
      $display("FAIL reset_idle: rv=%b flush=%b expected 0 0",
               rif0.redirect_valid, flush0);
    end else passed++;
  endtask

  task automatic test_compare_branch();
    ex_valid = 1; ex_set_flags = 1; {zero, sign, overflow} = 3'b100;
    tick();
    model_flags = 3'b100;
    total++;
    if (flags0 !== 3'b100) begin
      $display("FAIL cmp_flags: got %b expected 100", flags0);
    end else passed++;
    clear_inputs();
    drive_branch(3'd1, 1'b0, 36'h100, -25'sd4, 1'b0, 36'h0);
    tick();
    total++;
    if (rif0.redirect_valid !== 1'b1 || rif0.redirect_pc !== 36'h0FC ||
        stall0 !== 1'b1 || flush0 !== 1'b1) begin
      $display("FAIL cmp_branch: rv=%b pc=%h st=%b fl=%b expected 1 0fc 1 1",
               rif0.redirect_valid, rif0.redirect_pc, stall0, flush0);
    end else passed++;
    drain(0, 36'h0FC, 1'b0, "cmp_drain");
  endtask

  task automatic test_fused();
    drive_branch(3'd3, 1'b1, 36'h300, 25'd20, 1'b0, 36'h0);
    ex_set_flags = 1; {zero, sign, overflow} = 3'b010;
    tick();
    clear_inputs();
    model_flags = 3'b010;
    total++;
    if (rif0.redirect_valid !== 1'b0 || flush0 !== 1'b0 || stall0 !== 1'b0 ||
        flags0 !== 3'b010) begin
      $display("FAIL fused: rv=%b fl=%b st=%b flags=%b expected 0 0 0 010",
               rif0.redirect_valid, flush0, stall0, flags0);
    end else passed++;
  endtask

  task automatic test_backpressure();
    // Flags 010 give S^V=1, so GE is not taken; predicted taken mispredicts.
    drive_branch(3'd4, 1'b1, 36'h2000, 25'd100, 1'b0, 36'h0);
    tick();
    total++;
    if (rif0.redirect_valid !== 1'b1 || rif0.redirect_pc !== 36'h2001) begin
      $display("FAIL bp_raise: rv=%b pc=%h expected 1 2001",
               rif0.redirect_valid, rif0.redirect_pc);
    end else passed++;
    drain(3, 36'h2001, 1'b1, "backpressure");
  endtask

  task automatic test_wrap_indirect();
    drive_branch(3'd0, 1'b1, 36'hF_FFFF_FFFF, 25'd7, 1'b0, 36'h0);
    ex_set_flags = 1; {zero, sign, overflow} = 3'b100;
    tick();
    model_flags = 3'b100;
    total++;
    if (rif0.redirect_valid !== 1'b1 || rif0.redirect_pc !== 36'h0) begin
      $display("FAIL wrap: rv=%b pc=%h expected 1 0",
               rif0.redirect_valid, rif0.redirect_pc);
    end else passed++;
    drain(1, 36'h0, 1'b0, "wrap_drain");

    drive_branch(3'd7, 1'b0, 36'h777, 25'd5, 1'b1, 36'h1_2345_6789);
    tick();
    total++;
    if (rif0.redirect_valid !== 1'b1 || rif0.redirect_pc !== 36'h1_2345_6789) begin
      $display("FAIL indirect: rv=%b pc=%h expected 1 123456789",
               rif0.redirect_valid, rif0.redirect_pc);
    end else passed++;
    drain(0, 36'h1_2345_6789, 1'b0, "ind_drain");

    drive_branch(3'd7, 1'b0, 36'h900, 25'd5, 1'b0, 36'h0);
    ex_valid = 0;
    tick();
    clear_inputs();
    total++;
    if (rif0.redirect_valid !== 1'b0 || flush0 !== 1'b0) begin
      $display("FAIL no_ex_valid: rv=%b fl=%b expected 0 0",
               rif0.redirect_valid, flush0);
    end else passed++;
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [2:0]  src, live;
    logic [35:0] tgt, exp_pc;
    bit          tk, mis;
    for (int n = 0; n < 80; n++) begin
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_set_flags = $urandom_range(0, 1);
      live         = 3'($urandom_range(0, 7));
      {zero, sign, overflow} = live;
      br_valid     = ($urandom_range(0, 3) != 0);
      br_cond      = 3'($urandom_range(0, 7));
      br_indirect  = $urandom_range(0, 1);
      r = {$urandom, $urandom};
      br_pc        = r[35:0];
      r = {$urandom, $urandom};
      ex_data      = r[35:0];
      br_offset    = 25'($urandom);
      br_pred_taken = $urandom_range(0, 1);

      src = (ex_set_flags && br_valid) ? live : model_flags;
      tk  = ref_taken(br_cond, src[2], src[1], src[0]);
      tgt = br_indirect ? ex_data : ref_target(br_pc, br_offset);
      exp_pc = tk ? tgt : ref_fall(br_pc);
      mis = ex_valid && br_valid && (tk != br_pred_taken);
      if (ex_valid && ex_set_flags) model_flags = live;

      tick();
      total++;
      if (rif0.redirect_valid !== mis || flags0 !== model_flags ||
          (mis && rif0.redirect_pc !== exp_pc)) begin
        $display("FAIL rand%0d: rv=%b pc=%h flags=%b expected rv=%b pc=%h flags=%b",
                 n, rif0.redirect_valid, rif0.redirect_pc, flags0,
                 mis, exp_pc, model_flags);
      end else passed++;
      if (mis) drain($urandom_range(0, 2), exp_pc, 1'($urandom_range(0, 1)), "rand_drain");
    end
    clear_inputs();
  endtask

  task automatic test_flush_zero();
    bit          preds [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [35:0] tgt;
    #2 rst = 1;
    #2 rst = 0;
    clear_inputs();
    rif1.redirect_ready = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tgt = ref_target(36'h40 + 36'(i), 25'd8);
      drive_branch(3'd7, preds[i], 36'h40 + 36'(i), 25'd8, 1'b0, 36'h0);
      tick();
      clear_inputs();
      total++;
      if (rif1.redirect_valid !== !preds[i] ||
          (!preds[i] && rif1.redirect_pc !== tgt)) begin
        $display("FAIL fc0_br%0d: rv=%b pc=%h expected rv=%b pc=%h",
                 i, rif1.redirect_valid, rif1.redirect_pc, !preds[i], tgt);
      end else passed++;
      if (!preds[i]) begin
        tick();
        total++;
        if ({rif1.redirect_valid, stall1, flush1} !== 3'b000) begin
          $display("FAIL fc0_accept%0d: vsf=%b expected 000", i,
                   {rif1.redirect_valid, stall1, flush1});
        end else passed++;
      end
    end
`ifdef SCALAR_BR_PERF_EN
    total++;
    if (brc1 !== 32'd5 || misc1 !== 32'd2) begin
      $display("FAIL perf_counts: br=%0d mis=%0d expected 5 2", brc1, misc1);
    end else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_compare_branch();
    test_fused();
    test_backpressure();
    test_wrap_indirect();
    test_random();
    test_flush_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
